cpu_eu: RTL and testbench

- 16-bit execution unit (datapath) directly downstream of the CPU control unit.
- Consumes the control word: register addresses, mux selects, PC/IR controls, register write enable and ALU opcode.
- Holds PC, IR, an 8x16 register file and the ALU; drives the memory address and write data.
- Returns IR and the combinational N/Z/C flags to the control unit, which latches them.
- mw_en bypasses this block and goes straight to memory.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/cpu_regfile.sv | 39 +++
 rtl/cpu_eu.sv | 126 ++++++++++++
 tb/tb_cpu_eu.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath: widths, ALU opcodes, control field widths.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int REG_N    = 8;
  localparam int ALU_OP_W = 4;
  localparam int OFFS_W   = 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam logic [ALU_OP_W-1:0] ALU_PASS_S = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_R = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_INC    = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_DEC    = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SHR    = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SHL    = 4'b0111;

  // Branch offsets live in the low byte of IR and are signed.
  function automatic word_t sext_offs(input logic [OFFS_W-1:0] offs);
    return {{(DATA_W-OFFS_W){offs[OFFS_W-1]}}, offs};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8x16 register file: two combinational read ports, one write port, no write bypass.
// CPU_EU_DBG_EN adds a third combinational read port for board debug.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  reg_addr_t w_addr,
  input  logic      w_en,
  input  word_t     w_data,
  input  reg_addr_t r_addr,
  input  reg_addr_t s_addr,
  output word_t     r_data,
  output word_t     s_data
`ifdef CPU_EU_DBG_EN
  ,
  input  reg_addr_t dbg_addr,
  output word_t     dbg_data
`endif
);

  word_t regs [REG_N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (w_en) begin
      regs[w_addr] <= w_data;
    end
  end

  assign r_data = regs[r_addr];
  assign s_data = regs[s_addr];

`ifdef CPU_EU_DBG_EN
  assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: rtl/cpu_eu.sv
// 16-bit execution unit: PC, IR, register file and ALU, one control word per clock.
// CPU_EU_DBG_EN exposes a register debug read port and the PC.
module cpu_eu
  import cpu_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  W_addr,
  input  logic [2:0]  R_addr,
  input  logic [2:0]  S_addr,
  input  logic        adr_sel,
  input  logic        s_sel,
  input  logic        pc_ld,
  input  logic        pc_inc,
  input  logic        pc_sel,
  input  logic        ir_ld,
  input  logic        rw_en,
  input  logic [3:0]  alu_op,
  input  logic [15:0] D_in,
  output logic [15:0] Address,
  output logic [15:0] D_out,
  output logic [15:0] IR,
  output logic        N,
  output logic        Z,
  output logic        C
`ifdef CPU_EU_DBG_EN
  ,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_data,
  output logic [15:0] dbg_pc
`endif
);

  word_t pc;
  word_t r_val;
  word_t s_val;
  word_t alu_res;
  logic  alu_c;
  word_t w_data;

  assign w_data = s_sel ? D_in : alu_res;

  cpu_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .w_addr   (W_addr),
    .w_en     (rw_en),
    .w_data   (w_data),
    .r_addr   (R_addr),
    .s_addr   (S_addr),
    .r_data   (r_val),
    .s_data   (s_val)
`ifdef CPU_EU_DBG_EN
    ,
    .dbg_addr (dbg_sel),
    .dbg_data (dbg_data)
`endif
  );

  always_comb begin
    alu_res = s_val;
    alu_c   = 1'b0;
    case (alu_op)
      ALU_PASS_S: begin
        alu_res = s_val;
      end
      ALU_PASS_R: begin
        alu_res = r_val;
      end
      ALU_INC: begin
        {alu_c, alu_res} = {1'b0, s_val} + 17'd1;
      end
      ALU_DEC: begin
        alu_res = s_val - 16'd1;
        alu_c   = (s_val == '0);
      end
      ALU_ADD: begin
        {alu_c, alu_res} = {1'b0, r_val} + {1'b0, s_val};
      end
      ALU_SUB: begin
        alu_res = r_val - s_val;
        alu_c   = (r_val < s_val);
      end
      ALU_SHR: begin
        alu_res = {1'b0, s_val[15:1]};
        alu_c   = s_val[0];
      end
      ALU_SHL: begin
        alu_res = {s_val[14:0], 1'b0};
        alu_c   = s_val[15];
      end
      default: begin
        alu_res = s_val;
      end
    endcase
  end

  assign N = alu_res[15];
  assign Z = (alu_res == '0);
  assign C = alu_c;

  // Load beats increment; branch offset is relative to the PC already advanced past the branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= PC_RESET;
      IR <= '0;
    end else begin
      if (pc_ld) begin
        pc <= pc_sel ? s_val : (pc + sext_offs(IR[7:0]));
      end else if (pc_inc) begin
        pc <= pc + 16'd1;
      end
      if (ir_ld) IR <= D_in;
    end
  end

  assign Address = adr_sel ? r_val : pc;
  assign D_out   = s_val;

`ifdef CPU_EU_DBG_EN
  assign dbg_pc = pc;
`endif

endmodule

// File: tb/tb_cpu_eu.sv
// Directed self-checking bench for cpu_eu with hand-computed expected values.
module tb_cpu_eu;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  W_addr, R_addr, S_addr;
  logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, rw_en;
  logic [3:0]  alu_op;
  logic [15:0] D_in;
  logic [15:0] Address, D_out, IR;
  logic        N, Z, C;
`ifdef CPU_EU_DBG_EN
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data, dbg_pc;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_eu #(.PC_RESET(16'h0000)) dut (
    .clk     (clk),
    .reset   (reset),
    .W_addr  (W_addr),
    .R_addr  (R_addr),
    .S_addr  (S_addr),
    .adr_sel (adr_sel),
    .s_sel   (s_sel),
    .pc_ld   (pc_ld),
    .pc_inc  (pc_inc),
    .pc_sel  (pc_sel),
    .ir_ld   (ir_ld),
    .rw_en   (rw_en),
    .alu_op  (alu_op),
    .D_in    (D_in),
    .Address (Address),
    .D_out   (D_out),
    .IR      (IR),
    .N       (N),
    .Z       (Z),
    .C       (C)
`ifdef CPU_EU_DBG_EN
    ,
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .dbg_pc   (dbg_pc)
`endif
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    W_addr = 3'd0; R_addr = 3'd0; S_addr = 3'd0;
    adr_sel = 1'b0; s_sel = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0;
    pc_sel = 1'b0; ir_ld = 1'b0; rw_en = 1'b0; alu_op = 4'd0; D_in = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] v);
    idle();
    W_addr = a; D_in = v; s_sel = 1'b1; rw_en = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    idle();
    adr_sel = 1'b1; R_addr = a;
    #1;
    check_eq(tag, Address, exp);
    idle();
  endtask

  task automatic set_pc(input logic [15:0] v);
    wr_reg(3'd7, v);
    S_addr = 3'd7; pc_ld = 1'b1; pc_sel = 1'b1;
    tick();
    idle();
  endtask

  task automatic load_ir(input logic [15:0] v);
    idle();
    D_in = v; ir_ld = 1'b1;
    tick();
    idle();
  endtask

  // Flags are checked before the edge, then the result is written to R3 and read back.
  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [15:0] r,
                         input logic [15:0] s, input logic [15:0] res, input logic c);
    wr_reg(3'd1, r);
    wr_reg(3'd2, s);
    R_addr = 3'd1; S_addr = 3'd2; alu_op = op;
    #1;
    check_eq({tag, "_n"}, {15'd0, N}, {15'd0, res[15]});
    check_eq({tag, "_z"}, {15'd0, Z}, {15'd0, res == 16'h0000});
    check_eq({tag, "_c"}, {15'd0, C}, {15'd0, c});
    W_addr = 3'd3; rw_en = 1'b1;
    tick();
    rd_reg({tag, "_res"}, 3'd3, res);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #3;
    check_eq("rst_addr", Address, 16'h0000);
    check_eq("rst_dout", D_out, 16'h0000);
    check_eq("rst_ir", IR, 16'h0000);
    check_eq("rst_nzc", {13'd0, N, Z, C}, 16'h0002);
    #4 reset = 1'b1;
    tick();

    // Asynchronous reset in the middle of a run
    wr_reg(3'd5, 16'h7777);
    set_pc(16'h0042);
    load_ir(16'h1234);
    check_eq("pre_rst_pc", Address, 16'h0042);
    check_eq("pre_rst_ir", IR, 16'h1234);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_pc", Address, 16'h0000);
    check_eq("async_rst_ir", IR, 16'h0000);
    adr_sel = 1'b1; R_addr = 3'd5; S_addr = 3'd7;
    #1;
    check_eq("async_rst_r5", Address, 16'h0000);
    check_eq("async_rst_r7", D_out, 16'h0000);
    idle();
    #1 reset = 1'b1;
    tick();

    // Fetch: IR captures M[PC], PC advances
    set_pc(16'h0005);
    D_in = 16'hE0C2; ir_ld = 1'b1; pc_inc = 1'b1;
    tick();
    idle();
    check_eq("fetch_ir", IR, 16'hE0C2);
    check_eq("fetch_pc", Address, 16'h0006);

    wr_reg(3'd3, 16'h5555);
    alu_chk("add_wrap", 4'b0100, 16'h8000, 16'h8000, 16'h0000, 1'b1);
    alu_chk("sub_neg", 4'b0101, 16'h0003, 16'h0005, 16'hFFFE, 1'b1);
    alu_chk("sub_pos", 4'b0101, 16'h0009, 16'h0004, 16'h0005, 1'b0);
    alu_chk("pass_s", 4'b0000, 16'h1111, 16'h8421, 16'h8421, 1'b0);
    alu_chk("pass_r", 4'b0001, 16'h0F0F, 16'h1111, 16'h0F0F, 1'b0);
    alu_chk("inc_wrap", 4'b0010, 16'h0000, 16'hFFFF, 16'h0000, 1'b1);
    alu_chk("dec_zero", 4'b0011, 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
    alu_chk("shr", 4'b0110, 16'h0000, 16'h0003, 16'h0001, 1'b1);
    alu_chk("shl", 4'b0111, 16'h0000, 16'h8001, 16'h0002, 1'b1);
    alu_chk("op_other", 4'b1111, 16'h0001, 16'h4000, 16'h4000, 1'b0);

    // A read of the register being written sees the old value until the edge
    wr_reg(3'd5, 16'h1357);
    W_addr = 3'd5; D_in = 16'h2468; s_sel = 1'b1; rw_en = 1'b1;
    adr_sel = 1'b1; R_addr = 3'd5;
    #1;
    check_eq("no_bypass_old", Address, 16'h1357);
    tick();
    check_eq("no_bypass_new", Address, 16'h2468);
    idle();

    // Branches: backward, backward with pc_inc also set, forward
    set_pc(16'h0010);
    load_ir(16'h00FC);
    pc_ld = 1'b1;
    tick();
    idle();
    check_eq("br_back", Address, 16'h000C);
    set_pc(16'h0010);
    pc_ld = 1'b1; pc_inc = 1'b1;
    tick();
    idle();
    check_eq("br_ld_wins", Address, 16'h000C);
    load_ir(16'hFF05);
    set_pc(16'h0010);
    pc_ld = 1'b1;
    tick();
    idle();
    check_eq("br_fwd", Address, 16'h0015);
    load_ir(16'h0001);
    set_pc(16'hFFFF);
    pc_ld = 1'b1;
    tick();
    idle();
    check_eq("br_wrap", Address, 16'h0000);

    // Jump, increment wrap, LDI
    wr_reg(3'd2, 16'h1234);
    S_addr = 3'd2; pc_ld = 1'b1; pc_sel = 1'b1;
    tick();
    idle();
    check_eq("jmp", Address, 16'h1234);
    set_pc(16'hFFFF);
    pc_inc = 1'b1;
    tick();
    idle();
    check_eq("inc_wrap_pc", Address, 16'h0000);
    set_pc(16'h0020);
    D_in = 16'hBEEF; W_addr = 3'd4; s_sel = 1'b1; rw_en = 1'b1; pc_inc = 1'b1;
    tick();
    idle();
    check_eq("ldi_pc", Address, 16'h0021);
    rd_reg("ldi_r4", 3'd4, 16'hBEEF);

    // Store / load addressing
    wr_reg(3'd5, 16'h0080);
    wr_reg(3'd6, 16'hCAFE);
    adr_sel = 1'b1; R_addr = 3'd5; S_addr = 3'd6;
    #1;
    check_eq("sto_addr", Address, 16'h0080);
    check_eq("sto_dout", D_out, 16'hCAFE);
    W_addr = 3'd2; D_in = 16'h00AA; s_sel = 1'b1; rw_en = 1'b1;
    tick();
    idle();
    rd_reg("load_r2", 3'd2, 16'h00AA);
`ifdef CPU_EU_DBG_EN
    dbg_sel = 3'd2;
    #1;
    check_eq("dbg_data", dbg_data, 16'h00AA);
    check_eq("dbg_pc", dbg_pc, 16'h0021);
`endif

    // Every register, R0 included, holds its own value
    for (int i = 0; i < 8; i++) begin
      wr_reg(i[2:0], 16'hA000 + 16'(i * 16'h0111));
      exp_q.push_back(16'hA000 + 16'(i * 16'h0111));
    end
    for (int i = 0; i < 8; i++) begin
      rd_reg($sformatf("reg_dump_%0d", i), i[2:0], exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

`ifdef CPU_EU_DBG_EN
  initial dbg_sel = 3'd0;
`endif

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
